// File: rtl/flash_image_loader.sv
// Boot-time copier: reads an image byte-by-byte from parallel flash, packs little-endian
// 32-bit words into a one-burst buffer and hands each full burst to the SDRAM arbiter.
module flash_image_loader #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDRESS_WIDTH       = 22,
  parameter int FLASH_ADDRESS_WIDTH = 22,
  parameter int BURST_LEN           = 8,
  parameter int IMAGE_WORDS         = 4096,
  parameter int SRC_BASE            = 0,
  parameter int DEST_BASE           = 0,
  parameter int FLASH_WAIT          = 5
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset_n,
  input  logic                           i_Start,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic [FLASH_ADDRESS_WIDTH-1:0] o_FL_Address,
  output logic                           o_FL_CE_n,
  output logic                           o_FL_OE_n,
  input  logic [7:0]                     i_FL_Data,
  output logic                           o_MEM_Valid,
  output logic [ADDRESS_WIDTH-1:0]       o_MEM_Address,
  output logic [DATA_WIDTH-1:0]          o_MEM_Data,
  input  logic                           i_MEM_Data_Read,
  input  logic                           i_MEM_Last
);

  localparam int WIW   = $clog2(IMAGE_WORDS + 1);
  localparam int PW    = $clog2(BURST_LEN);
  localparam int WAITW = $clog2(FLASH_WAIT);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [WIW-1:0]          word_idx_q;
  logic [1:0]              lane_q;
  logic [WAITW-1:0]        wait_q;
  logic [23:0]             asm_q;
  logic [PW:0]             wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   buf_q [BURST_LEN];

  logic byte_strobe;
  assign byte_strobe = (state_q == FETCH) && (wait_q == WAITW'(FLASH_WAIT - 1));

  // Flash and arbiter strobes are decoded from state so an asynchronous reset
  // deselects the flash and withdraws the burst request immediately.
  assign o_FL_CE_n     = (state_q != FETCH);
  assign o_FL_OE_n     = (state_q != FETCH);
  assign o_FL_Address  = (state_q == FETCH)
                         ? FLASH_ADDRESS_WIDTH'(SRC_BASE) + (FLASH_ADDRESS_WIDTH'(word_idx_q) << 2)
                           + FLASH_ADDRESS_WIDTH'(lane_q)
                         : '0;
  assign o_MEM_Valid   = (state_q == WRITE);
  assign o_MEM_Address = (state_q == WRITE)
                         ? ADDRESS_WIDTH'(DEST_BASE) + ADDRESS_WIDTH'(word_idx_q) - ADDRESS_WIDTH'(BURST_LEN)
                         : '0;
  assign o_MEM_Data    = (state_q == WRITE) ? buf_q[rd_ptr_q] : '0;
  assign o_Busy        = busy_q;
  assign o_Done        = done_q;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      lane_q     <= '0;
      wait_q     <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_Start) begin
            state_q    <= FETCH;
            word_idx_q <= '0;
            lane_q     <= '0;
            wait_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        FETCH: begin
          if (byte_strobe) begin
            wait_q <= '0;
            lane_q <= lane_q + 2'd1;
            if (lane_q != 2'd3) begin
              asm_q[8*lane_q +: 8] <= i_FL_Data;
            end else begin
              wr_ptr_q   <= wr_ptr_q + (PW+1)'(1);
              word_idx_q <= word_idx_q + WIW'(1);
              if (wr_ptr_q == (PW+1)'(BURST_LEN - 1)) state_q <= WRITE;
            end
          end else begin
            wait_q <= wait_q + WAITW'(1);
          end
        end
        WRITE: begin
          if (i_MEM_Data_Read && (rd_ptr_q != PW'(BURST_LEN - 1))) rd_ptr_q <= rd_ptr_q + PW'(1);
          // Last wins over a simultaneous read: the burst is over either way.
          if (i_MEM_Last) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            if (word_idx_q == WIW'(IMAGE_WORDS)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Burst buffer holds data only, so it carries no reset.
  always_ff @(posedge i_Clk) begin
    if (byte_strobe && (lane_q == 2'd3)) buf_q[wr_ptr_q[PW-1:0]] <= {i_FL_Data, asm_q};
  end

endmodule

// File: tb/tb_flash_image_loader.sv
// Bench for flash_image_loader: a flash byte model, a randomised arbiter and a word-level
// image model checking every consumed word, burst address, timing and control handshake.
module tb_flash_image_loader;

  localparam int IW   = 32;
  localparam int BL   = 8;
  localparam int SRC  = 64;
  localparam int DEST = 'h100;
  localparam int NB   = IW / BL;

  logic        clk = 0;
  logic        rst_n;
  logic        i_Start;
  logic        o_Busy, o_Done;
  logic [21:0] o_FL_Address;
  logic        o_FL_CE_n, o_FL_OE_n;
  logic [7:0]  i_FL_Data;
  logic        o_MEM_Valid;
  logic [21:0] o_MEM_Address;
  logic [31:0] o_MEM_Data;
  logic        i_MEM_Data_Read, i_MEM_Last;

  flash_image_loader #(
    .IMAGE_WORDS(IW), .BURST_LEN(BL), .SRC_BASE(SRC), .DEST_BASE(DEST), .FLASH_WAIT(5)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(i_Start), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_FL_Address(o_FL_Address), .o_FL_CE_n(o_FL_CE_n), .o_FL_OE_n(o_FL_OE_n),
    .i_FL_Data(i_FL_Data), .o_MEM_Valid(o_MEM_Valid), .o_MEM_Address(o_MEM_Address),
    .o_MEM_Data(o_MEM_Data), .i_MEM_Data_Read(i_MEM_Data_Read), .i_MEM_Last(i_MEM_Last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Flash contents: each byte is its address low byte xor a per-load seed.
  logic [7:0] seed = 8'h00;
  assign i_FL_Data = (!o_FL_CE_n && !o_FL_OE_n) ? (o_FL_Address[7:0] ^ seed) : 8'hEE;

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(SRC + 4*k + j) ^ seed;
    return w;
  endfunction

  // Arbiter model and burst scoreboard
  int rd_pct = 100, early = 0, burst_no = 0, beat = 0, words = 0, reads = 0;
  int rise_cyc = -1, start_cyc = 0;
  logic prev_rd, prev_last, in_burst, rd, last;
  logic [31:0] prev_data, burst_addr;

  initial begin
    i_MEM_Data_Read = 0; i_MEM_Last = 0;
    prev_rd = 0; prev_last = 0; in_burst = 0; prev_data = 0; burst_addr = 0;
    forever begin
      @(negedge clk);
      rd = 0; last = 0;
      if (!rst_n) begin
        prev_rd = 0; prev_last = 0; in_burst = 0;
      end else begin
        if (prev_last) begin
          chk("valid_fall_after_last", o_MEM_Valid, 0);
          chk("done_after_last", o_Done, (burst_no == NB));
          in_burst = 0;
        end else if (in_burst) begin
          chk("valid_hold", o_MEM_Valid, 1);
          chk("addr_hold", o_MEM_Address, burst_addr);
          if (!prev_rd) chk("data_hold", o_MEM_Data, prev_data);
        end
        if (o_MEM_Valid && !in_burst) begin
          in_burst = 1; beat = 0; burst_addr = o_MEM_Address;
          chk("burst_addr", o_MEM_Address, DEST + BL*burst_no);
          if (burst_no == 0) rise_cyc = cyc;
          burst_no++;
        end
        if (in_burst && o_MEM_Valid) begin
          rd = ($urandom_range(99) < rd_pct);
          if (rd) begin
            chk("word", o_MEM_Data, exp_word(int'(burst_addr) - DEST + beat));
            beat++; words++; reads++;
            last = (beat == ((early != 0 && burst_no == 1) ? 2 : BL));
          end
        end
      end
      prev_rd = rd; prev_last = last; prev_data = o_MEM_Data;
      if (in_burst || !rst_n) begin
        i_MEM_Data_Read = rd; i_MEM_Last = last;
      end else begin
        // Stray handshakes outside a burst must be ignored.
        i_MEM_Data_Read = 1'($urandom_range(1));
        i_MEM_Last      = ($urandom_range(7) == 0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); #2 i_Start = 1;
    @(negedge clk); #2 i_Start = 0;
  endtask

  task automatic do_start();
    @(negedge clk); #2;
    burst_no = 0; words = 0; reads = 0; rise_cyc = -1; start_cyc = cyc;
    i_Start = 1;
    @(negedge clk); #2 i_Start = 0;
    chk("busy_after_start", o_Busy, 1);
    chk("done_clear_after_start", o_Done, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Done) break;
    end
    #1;
    chk("load_done", o_Done, 1);
    chk("busy_low_when_done", o_Busy, 0);
  endtask

  initial begin
    rst_n = 0; i_Start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_ce_n", o_FL_CE_n, 1);
    chk("rst_oe_n", o_FL_OE_n, 1);
    chk("rst_fl_addr", o_FL_Address, 0);
    chk("rst_valid", o_MEM_Valid, 0);
    chk("rst_mem_addr", o_MEM_Address, 0);
    chk("rst_mem_data", o_MEM_Data, 0);
    @(negedge clk) rst_n = 1;

    // Full-rate arbiter, identity flash contents
    seed = 8'h00; rd_pct = 100;
    do_start();
    chk("first_fl_addr", o_FL_Address, SRC);
    chk("fetch_ce_n", o_FL_CE_n, 0);
    wait_done(2000);
    chk("valid_rise_latency", rise_cyc - start_cyc, 161);
    chk("bursts_load1", burst_no, NB);
    chk("words_load1", words, IW);

    // Stalling arbiter, restart from DONE, starts while busy ignored
    seed = 8'($urandom); rd_pct = 30;
    do_start();
    repeat (50) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 400 && !o_MEM_Valid; i++) @(negedge clk);
    pulse_start();
    wait_done(6000);
    chk("bursts_load2", burst_no, NB);
    chk("words_load2", words, IW);

    // Reset in the middle of a burst
    seed = 8'($urandom); rd_pct = 100;
    do_start();
    for (int i = 0; i < 400 && reads < 3; i++) @(negedge clk);
    chk("reads_before_reset", reads, 3);
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("async_rst_valid", o_MEM_Valid, 0);
    chk("async_rst_ce_n", o_FL_CE_n, 1);
    chk("async_rst_busy", o_Busy, 0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1;
    seed = 8'($urandom); rd_pct = 60;
    do_start();
    chk("restart_fl_addr", o_FL_Address, SRC);
    wait_done(4000);
    chk("bursts_restart", burst_no, NB);
    chk("words_restart", words, IW);

    // Early Last on the first burst
    seed = 8'($urandom); rd_pct = 100; early = 1;
    do_start();
    wait_done(2000);
    early = 0;
    chk("bursts_early", burst_no, NB);
    chk("words_early", words, 2 + (NB - 1) * BL);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flash_image_loader.md
# flash_image_loader

Boot-time copier that reads a program image byte-by-byte from the external 8-bit parallel flash and writes it into SDRAM as 32-bit words. It assembles bytes into little-endian words and buffers one burst of words. It then presents the burst to the memory arbiter's flash port, which has the highest priority. It runs once per i_Start and holds off the CPU via o_Busy until the image is resident.

## Interface
- DATA_WIDTH, 32, SDRAM word width (must be 32)
- ADDRESS_WIDTH, 22, SDRAM word-address width
- FLASH_ADDRESS_WIDTH, 22, flash byte-address width
- BURST_LEN, 8, words per SDRAM write burst (power of two, 2..16)
- IMAGE_WORDS, 4096, words copied per load (multiple of BURST_LEN)
- SRC_BASE, 0, flash byte address of image word 0
- DEST_BASE, 0, SDRAM word address of image word 0
- FLASH_WAIT, 5, clocks per flash byte access (>= 2)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- i_Clk  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle pulse begins a load; ignored unless IDLE or DONE
- o_Busy  out  1  high from the cycle after an accepted i_Start until load completes
- o_Done  out  1  high after a completed load until the next accepted i_Start
- o_FL_Address  out  FLASH_ADDRESS_WIDTH  flash byte address
- o_FL_CE_n  out  1  flash chip enable, active low
- o_FL_OE_n  out  1  flash output enable, active low
- i_FL_Data  in  8  flash read data
- o_MEM_Valid  out  1  write-burst request to arbiter
- o_MEM_Address  out  ADDRESS_WIDTH  burst start word address, constant for the burst
- o_MEM_Data  out  DATA_WIDTH  current write word
- i_MEM_Data_Read  in  1  arbiter consumed o_MEM_Data this cycle
- i_MEM_Last  in  1  final beat of the burst

## Operation
- State machine has four states: IDLE, FETCH, WRITE, DONE.
- IDLE/DONE with i_Start: go to FETCH. Clear word count, byte lane, buffer pointers and o_Done; set o_Busy.
- FETCH:
  - o_FL_CE_n and o_FL_OE_n are held low for the whole state.
  - o_FL_Address = SRC_BASE + 4*word_index + lane.
  - A wait counter runs 0..FLASH_WAIT-1. On count FLASH_WAIT-1, i_FL_Data is registered into bits [8*lane+7:8*lane], the lane increments and the counter clears.
  - After lane 3, the assembled word is written to buffer[wr_ptr], and wr_ptr and word_index increment.
  - When wr_ptr reaches BURST_LEN, go to WRITE. CE_n and OE_n return high.
- WRITE:
  - o_MEM_Valid = 1 (decoded from state).
  - o_MEM_Address = DEST_BASE + (word_index - BURST_LEN).
  - o_MEM_Data = buffer[rd_ptr]. rd_ptr increments on i_MEM_Data_Read and saturates at BURST_LEN-1.
  - On i_MEM_Last, pointers clear. If word_index == IMAGE_WORDS go to DONE, else go to FETCH.
- DONE: o_Done = 1, o_Busy = 0.
- i_MEM_Last ends the burst regardless of how many words were consumed. No retry is made.
- o_MEM_Valid stays high continuously from WRITE entry until i_MEM_Last; it never drops mid-burst.
- i_MEM_Data_Read and i_MEM_Last outside WRITE are ignored.

## Timing
- Reset values:
  - Control/status: state IDLE; o_Busy 0; o_Done 0.
  - Flash interface: o_FL_CE_n 1; o_FL_OE_n 1; o_FL_Address 0.
  - Memory interface: o_MEM_Valid 0; o_MEM_Address 0; o_MEM_Data 0.
  - Internal: all counters and pointers 0.
- Reset mid-load drops o_MEM_Valid and deselects the flash asynchronously. The next load restarts from word 0.
- Start to first flash address: FETCH is entered 1 cycle after i_Start.
- Byte: FLASH_WAIT cycles. Word: 4*FLASH_WAIT cycles. Burst fill: 4*FLASH_WAIT*BURST_LEN cycles.
- o_MEM_Valid rises the cycle after the final byte is sampled.
- o_MEM_Valid falls the cycle after i_MEM_Last. This guarantees the arbiter's ready state sees it low and does not re-grant.
- Data_Read in cycle n: o_MEM_Data shows the next word in cycle n+1.
- Data_Read and Last in the same cycle: both are honoured, then the pointers clear.
- i_Start while busy: no effect.
- i_Start in DONE: a new load begins.

## Test plan
- Reset test: i_Reset_n low -> every output at its reset value; CE_n/OE_n = 1.
- Single burst (IMAGE_WORDS=8, FLASH_WAIT=5):
  - Stimulus: flash model returns byte = address[7:0]; arbiter model asserts Data_Read every cycle and Last with the 8th word.
  - Required response: words 0x03020100 … 0x1F1E1D1C written at DEST_BASE, with o_MEM_Valid first high 161 cycles after i_Start.
  - Required response: o_Done=1 one cycle after Last; Valid low that cycle.
- Multi-burst stalls (IMAGE_WORDS=32):
  - Stimulus: Data_Read given randomly 30% of cycles.
  - Required response: 4 bursts at addresses DEST_BASE+0, +8, +16, +24; o_MEM_Data stable while Data_Read is low; Valid never drops mid-burst.
- Start while busy: pulse i_Start during FETCH and WRITE -> no restart; word count continues; total 32 words written once.
- Reset mid-WRITE: assert reset after 3 Data_Reads -> Valid 0 immediately; after release and i_Start, the copy restarts from flash address SRC_BASE and SDRAM address DEST_BASE.
- Early Last: Last after 2 Data_Reads -> burst ends, FETCH resumes for the next burst, and the next o_MEM_Address is DEST_BASE+8.
